latch_debounce: RTL and testbench



---
 rtl/latch_debounce_pkg.sv | 25 ++
 rtl/latch_debounce_sync2.sv | 27 ++
 rtl/latch_debounce.sv | 142 ++++++++++++++
 tb/tb_latch_debounce.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_debounce_pkg.sv
// Shared definitions for the latch conditioning stage: FSM encoding and sizing helper.
package latch_debounce_pkg;

    // Debounce FSM states; the encoding is shared with later stages that decode it.
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_e;

    // Ceiling log2, used to size counters from parameters at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/latch_debounce_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; reused by other cross-domain stages.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic s_q;

    // Shift the raw level through two flops; only the second is safe to consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage pipeline;
            // blocking ones would collapse both flops into one.
            sync1_q <= d_i;
            s_q     <= sync1_q;
        end
    end

    assign q_o = s_q;

endmodule

// File: rtl/latch_debounce.sv
// Debounces the synchronised latch output, emits edge pulses and counts qualified rises.
module latch_debounce
    import latch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             cnt_clr,
    output logic             q_clean,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int STAB_W = clog2(STABLE_CYCLES + 1);
    // stab holds the samples already seen, so the accepting sample arrives when stab is N-1.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    // With a one-sample requirement the first differing sample is already enough.
    localparam bit ACCEPT_ON_FIRST = (STABLE_CYCLES == 1);

    logic s;

    state_e            state_q,    state_d;
    logic [STAB_W-1:0] stab_q,     stab_d;
    logic              q_clean_q,  q_clean_d;
    logic              rise_q,     rise_d;
    logic              fall_q,     fall_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (d_in),
        .q_o (s)
    );

    // Next-state logic: qualify a new level only after an unbroken run of matching samples.
    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        stab_d    = stab_q;
        q_clean_d = q_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    if (ACCEPT_ON_FIRST) begin
                        state_d   = IDLE_HI;
                        q_clean_d = 1'b1;
                        rise_d    = 1'b1;
                        stab_d    = '0;
                    end else begin
                        state_d = WAIT_HI;
                        stab_d  = STAB_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d   = IDLE_HI;
                    q_clean_d = 1'b1;
                    rise_d    = 1'b1;
                    stab_d    = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    if (ACCEPT_ON_FIRST) begin
                        state_d   = IDLE_LO;
                        q_clean_d = 1'b0;
                        fall_d    = 1'b1;
                        stab_d    = '0;
                    end else begin
                        state_d = WAIT_LO;
                        stab_d  = STAB_W'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d   = IDLE_LO;
                    q_clean_d = 1'b0;
                    fall_d    = 1'b1;
                    stab_d    = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE_LO;
                stab_d    = '0;
                q_clean_d = 1'b0;
            end
        endcase

        // A clear wins over a coincident rise, so that edge is deliberately lost.
        edge_cnt_d = edge_cnt_q;
        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if (rise_d) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    // State and output registers; reset forces the low idle state even mid-qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE_LO;
            stab_q     <= '0;
            q_clean_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_q     <= stab_d;
            q_clean_q  <= q_clean_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign q_clean  = q_clean_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_latch_debounce.sv
// Bench for latch_debounce: directed scenarios plus randomized traffic against a sample-history model.
module tb_latch_debounce;
    import latch_debounce_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic cnt_clr;
    logic d_in;

    // Input source: either driven directly or through a behavioural D latch.
    logic use_latch;
    logic d_direct;
    logic lat_en;
    logic lat_d;
    logic lat_q;

    logic       q_a, rise_a, fall_a;
    logic [7:0] cnt_a;
    logic       q_b, rise_b, fall_b;
    logic [1:0] cnt_b;
    logic       q_c, rise_c, fall_c;
    logic [7:0] cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Level-sensitive latch standing in for the upstream stage.
    always_latch begin
        if (lat_en) lat_q <= lat_d;
    end

    assign d_in = use_latch ? lat_q : d_direct;

    latch_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .d_in(d_in), .cnt_clr(cnt_clr),
        .q_clean(q_a), .rise(rise_a), .fall(fall_a), .edge_cnt(cnt_a));

    latch_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_in), .cnt_clr(cnt_clr),
        .q_clean(q_b), .rise(rise_b), .fall(fall_b), .edge_cnt(cnt_b));

    latch_debounce #(.STABLE_CYCLES(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .d_in(d_in), .cnt_clr(cnt_clr),
        .q_clean(q_c), .rise(rise_c), .fall(fall_c), .edge_cnt(cnt_c));

    // ---------------- reference model ----------------
    // The level flips once the last N samples seen by the filter all differ from it.
    // Index 0 models STABLE_CYCLES=4 (dut_a, dut_b), index 1 models STABLE_CYCLES=1 (dut_c).
    int unsigned m_n [2] = '{4, 1};
    bit          m_q    [2];
    bit          m_rise [2];
    bit          m_fall [2];
    int unsigned m_cnt  [2];
    bit          m_dl0, m_dl1;
    bit          m_hist [$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_dl0 = 1'b0;
                m_dl1 = 1'b0;
                m_hist.delete();
                for (int i = 0; i < 2; i++) begin
                    m_q[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_cnt[i] = 0;
                end
            end else begin
                bit s_seen;
                s_seen = m_dl1;
                m_dl1  = m_dl0;
                m_dl0  = d_in;
                m_hist.push_back(s_seen);
                if (m_hist.size() > 4) void'(m_hist.pop_front());
                for (int i = 0; i < 2; i++) begin
                    bit flip;
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    flip = (m_hist.size() >= int'(m_n[i]));
                    for (int j = 0; j < int'(m_n[i]); j++) begin
                        if (flip && m_hist[m_hist.size() - 1 - j] == m_q[i]) flip = 1'b0;
                    end
                    if (flip) begin
                        m_q[i]    = ~m_q[i];
                        m_rise[i] = m_q[i];
                        m_fall[i] = ~m_q[i];
                    end
                    if (cnt_clr)        m_cnt[i] = 0;
                    else if (m_rise[i]) m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    task automatic pulse_pair();
        d_direct = 1'b1;
        tick(8);
        d_direct = 1'b0;
        tick(8);
    endtask

    // ---------------- scenarios ----------------
    // Reset with d_in high: outputs held at 0, then a normal qualification after release.
    // k counts edges after release; k=0 is the first edge sampling d_in into the synchroniser.
    task automatic test_reset();
        rst = 1'b1; d_direct = 1'b1; use_latch = 1'b0; cnt_clr = 1'b0;
        lat_en = 1'b1; lat_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({q_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: got %b want all zero", k, {q_a, rise_a, fall_a, cnt_a});
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (q_a !== (k >= 5) || rise_a !== (k == 5) || fall_a !== 1'b0 || cnt_a !== ((k >= 5) ? 8'd1 : 8'd0)) begin
                n_err++;
                $display("FAIL reset_release k=%0d: got q=%b r=%b f=%b cnt=%0d want q=%b r=%b f=0 cnt=%0d",
                         k, q_a, rise_a, fall_a, cnt_a, k >= 5, k == 5, (k >= 5) ? 1 : 0);
            end
        end
    endtask

    // Clean 0->1: q_clean exactly five edges after the first sampling edge.
    task automatic test_clean_rise();
        d_direct = 1'b0;
        tick(10);
        clear_counts();
        d_direct = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (q_a !== (k >= 5) || rise_a !== (k == 5) || fall_a !== 1'b0 || cnt_a !== ((k >= 5) ? 8'd1 : 8'd0)) begin
                n_err++;
                $display("FAIL clean_rise k=%0d: got q=%b r=%b f=%b cnt=%0d want q=%b r=%b f=0 cnt=%0d",
                         k, q_a, rise_a, fall_a, cnt_a, k >= 5, k == 5, (k >= 5) ? 1 : 0);
            end
        end
        d_direct = 1'b0;
        tick(10);
    endtask

    // Three-sample high glitch: reaches stab=3 in WAIT_HI, then is abandoned.
    task automatic test_glitch();
        d_direct = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) d_direct = 1'b0;
            n_cmp++;
            if (q_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0 || cnt_a !== 8'd1) begin
                n_err++;
                $display("FAIL glitch k=%0d: got q=%b r=%b f=%b cnt=%0d want q=0 r=0 f=0 cnt=1",
                         k, q_a, rise_a, fall_a, cnt_a);
            end
            if (k == 4) begin
                n_cmp++;
                if (dut_a.state_q !== WAIT_HI || dut_a.stab_q !== 3'd3) begin
                    n_err++;
                    $display("FAIL glitch_peak: got state=%b stab=%0d want state=01 stab=3",
                             dut_a.state_q, dut_a.stab_q);
                end
            end
        end
        n_cmp++;
        if (dut_a.state_q !== IDLE_LO || dut_a.stab_q !== 3'd0) begin
            n_err++;
            $display("FAIL glitch_idle: got state=%b stab=%0d want state=00 stab=0", dut_a.state_q, dut_a.stab_q);
        end
    endtask

    // Four rise/fall pairs on the 2-bit counter: counts 1,2,3,0 and one fall each.
    task automatic test_fall_wrap();
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            int rises;
            int falls;
            rises = 0;
            falls = 0;
            d_direct = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                rises += int'(rise_b);
                falls += int'(fall_b);
            end
            n_cmp++;
            if (rises != 1 || falls != 0 || cnt_b !== 2'((i + 1) % 4)) begin
                n_err++;
                $display("FAIL wrap_rise %0d: got rises=%0d falls=%0d cnt=%0d want 1 0 %0d",
                         i, rises, falls, cnt_b, (i + 1) % 4);
            end
            rises = 0;
            d_direct = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                rises += int'(rise_b);
                falls += int'(fall_b);
            end
            n_cmp++;
            if (falls != 1 || rises != 0 || q_b !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_fall %0d: got falls=%0d rises=%0d q=%b want 1 0 0", i, falls, rises, q_b);
            end
        end
    endtask

    // cnt_clr coinciding with the edge that produces a rise: count ends at 0.
    task automatic test_clear_collision();
        clear_counts();
        repeat (5) pulse_pair();
        n_cmp++;
        if (cnt_a !== 8'd5) begin
            n_err++;
            $display("FAIL collide_pre: got cnt=%0d want 5", cnt_a);
        end
        d_direct = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 4) cnt_clr = 1'b1;
            if (k == 5) begin
                cnt_clr = 1'b0;
                n_cmp++;
                if (rise_a !== 1'b1 || cnt_a !== 8'd0) begin
                    n_err++;
                    $display("FAIL collide: got rise=%b cnt=%0d want rise=1 cnt=0", rise_a, cnt_a);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (cnt_a !== 8'd0 || q_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL collide_after: got cnt=%0d q=%b want cnt=0 q=1", cnt_a, q_a);
                end
            end
        end
        d_direct = 1'b0;
        tick(10);
    endtask

    // Reset while WAIT_HI with stab=2 abandons the qualification.
    task automatic test_mid_reset();
        d_direct = 1'b1;
        tick(4);
        n_cmp++;
        if (dut_a.state_q !== WAIT_HI || dut_a.stab_q !== 3'd2) begin
            n_err++;
            $display("FAIL midrst_pre: got state=%b stab=%0d want state=01 stab=2", dut_a.state_q, dut_a.stab_q);
        end
        rst = 1'b1;
        d_direct = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_a.state_q !== IDLE_LO || dut_a.stab_q !== 3'd0 || q_a !== 1'b0 || rise_a !== 1'b0) begin
            n_err++;
            $display("FAIL midrst: got state=%b stab=%0d q=%b r=%b want 00 0 0 0",
                     dut_a.state_q, dut_a.stab_q, q_a, rise_a);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rise_a !== 1'b0 || q_a !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_after k=%0d: got r=%b q=%b want 0 0", k, rise_a, q_a);
            end
        end
    endtask

    // Random levels with random hold lengths, direct then through the latch, against the model.
    task automatic test_random();
        int  hold;
        bit  prev_pulse;
        logic [24:0] obs;
        logic [24:0] exp_v;
        hold = 0;
        prev_pulse = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            obs   = {q_a, rise_a, fall_a, cnt_a, q_b, cnt_b, q_c, rise_c, fall_c, cnt_c};
            exp_v = {m_q[0], m_rise[0], m_fall[0], m_cnt[0][7:0], m_q[0], m_cnt[0][1:0],
                     m_q[1], m_rise[1], m_fall[1], m_cnt[1][7:0]};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b want %b", cyc, obs, exp_v);
            end
            n_cmp++;
            if ((rise_a && fall_a) || ((rise_a || fall_a) && prev_pulse)) begin
                n_err++;
                $display("FAIL pulse_spacing cyc %0d: got r=%b f=%b prev=%b want isolated pulse",
                         cyc, rise_a, fall_a, prev_pulse);
            end
            prev_pulse = rise_a || fall_a;
            cnt_clr = ($urandom_range(0, 15) == 0);
            if (cyc == 600) begin
                lat_d = d_direct;
                lat_en = 1'b1;
                #1;
                use_latch = 1'b1;
            end
            if (hold == 0) hold = $urandom_range(1, 7);
            hold--;
            if (!use_latch) begin
                if (hold == 0) d_direct = ~d_direct;
            end else begin
                #2;
                lat_en = ($urandom_range(0, 3) != 0);
                if (hold == 0) lat_d = ~lat_d;
            end
        end
        cnt_clr = 1'b0;
        use_latch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_fall_wrap();
        test_clear_collision();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run; the scenarios above need far less time than this.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
